// File: rtl/uart_frame_parser.sv
// Parses HDR/LEN/payload/CHK frames from a UART byte stream, streaming payload
// bytes out as they arrive and flagging completion, length, checksum and timeout errors.
module uart_frame_parser #(
    parameter logic [7:0] HDR_BYTE    = 8'hA5,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_done_i,
    output logic [7:0] pl_data_o,
    output logic       pl_valid_o,
    output logic [7:0] pl_idx_o,
    output logic       frame_ok_o,
    output logic       frame_err_o,
    output logic [1:0] err_code_o,
    output logic       busy_o,
    output logic [1:0] dbg_state_o
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ERR_LEN = 2'b01;
    localparam logic [1:0] ERR_CHK = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_DATA = 2'd2,
        ST_CHK  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [7:0]    len_q, len_n;
    logic [7:0]    acc_q, acc_n;
    logic [7:0]    idx_q, idx_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [7:0]    pl_data_n, pl_idx_n;
    logic          pl_valid_n, ok_n, err_n, busy_n;
    logic [1:0]    code_n;

    assign dbg_state_o = state;

    always_comb begin
        state_n    = state;
        len_n      = len_q;
        acc_n      = acc_q;
        idx_n      = idx_q;
        cnt_n      = cnt_q;
        pl_data_n  = pl_data_o;
        pl_idx_n   = pl_idx_o;
        pl_valid_n = 1'b0;
        ok_n       = 1'b0;
        err_n      = 1'b0;
        code_n     = err_code_o;

        // A byte arriving in the expiry cycle wins: the case below overrides the timeout.
        if (state != ST_IDLE) begin
            if (rx_done_i) begin
                cnt_n = '0;
            end else if (cnt_q == TMO_LAST) begin
                err_n   = 1'b1;
                code_n  = ERR_TMO;
                state_n = ST_IDLE;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt_q + 1'b1;
            end
        end

        if (rx_done_i) begin
            case (state)
                ST_IDLE: begin
                    if (rx_data_i == HDR_BYTE) begin
                        state_n = ST_LEN;
                        cnt_n   = '0;
                    end
                end
                ST_LEN: begin
                    if (rx_data_i == 8'd0 || rx_data_i > 8'(MAX_LEN)) begin
                        err_n   = 1'b1;
                        code_n  = ERR_LEN;
                        state_n = ST_IDLE;
                    end else begin
                        len_n   = rx_data_i;
                        acc_n   = rx_data_i;
                        idx_n   = 8'd0;
                        state_n = ST_DATA;
                    end
                end
                ST_DATA: begin
                    pl_data_n  = rx_data_i;
                    pl_idx_n   = idx_q;
                    pl_valid_n = 1'b1;
                    acc_n      = acc_q + rx_data_i;
                    idx_n      = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) state_n = ST_CHK;
                end
                ST_CHK: begin
                    if (rx_data_i == acc_q) begin
                        ok_n = 1'b1;
                    end else begin
                        err_n  = 1'b1;
                        code_n = ERR_CHK;
                    end
                    state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end

        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            len_q       <= 8'd0;
            acc_q       <= 8'd0;
            idx_q       <= 8'd0;
            cnt_q       <= '0;
            pl_data_o   <= 8'd0;
            pl_idx_o    <= 8'd0;
            pl_valid_o  <= 1'b0;
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;
            err_code_o  <= 2'b00;
            busy_o      <= 1'b0;
        end else begin
            state       <= state_n;
            len_q       <= len_n;
            acc_q       <= acc_n;
            idx_q       <= idx_n;
            cnt_q       <= cnt_n;
            pl_data_o   <= pl_data_n;
            pl_idx_o    <= pl_idx_n;
            pl_valid_o  <= pl_valid_n;
            frame_ok_o  <= ok_n;
            frame_err_o <= err_n;
            err_code_o  <= code_n;
            busy_o      <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed frames plus random byte streams, checked
// against a frame-position reference model through a timestamped expected-event queue.
module tb_uart_frame_parser;

    localparam logic [7:0] HDR  = 8'hA5;
    localparam int         MAXL = 16;
    localparam int         TMO  = 40;
    localparam int         W    = 52;   // {cycle[31:0], kind[1:0], data[7:0], idx[7:0], code[1:0]}

    localparam logic [1:0] K_PL  = 2'd0;
    localparam logic [1:0] K_OK  = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    logic       clk, rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] pl_data, pl_idx;
    logic       pl_valid, frame_ok, frame_err, busy;
    logic [1:0] err_code, dbg_state;

    uart_frame_parser #(.HDR_BYTE(HDR), .MAX_LEN(MAXL), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_done_i(rx_done),
        .pl_data_o(pl_data), .pl_valid_o(pl_valid), .pl_idx_o(pl_idx),
        .frame_ok_o(frame_ok), .frame_err_o(frame_err), .err_code_o(err_code),
        .busy_o(busy), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // pos 0: hunting for header, 1: expecting length, 2..len+1: payload, len+2: checksum
    int         pos    = 0;
    int         mlen   = 0;
    int         last_c = 0;
    logic [7:0] pay_q[$];

    function automatic void push_ev(input int c, input logic [1:0] kind, input logic [7:0] d,
                                    input logic [7:0] ix, input logic [1:0] code);
        logic [31:0] cv;
        cv = c;
        exp_q.push_back({cv, kind, d, ix, code});
    endfunction

    function automatic void model_tick_to(input int d);
        if (pos != 0 && d > last_c + TMO) begin
            push_ev(last_c + TMO + 1, K_ERR, 8'd0, 8'd0, 2'b11);
            pos = 0;
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b, input int c);
        int s;
        model_tick_to(c);
        if (pos == 0) begin
            if (b == HDR) pos = 1;
        end else if (pos == 1) begin
            if (b == 8'd0 || int'(b) > MAXL) begin
                push_ev(c + 1, K_ERR, 8'd0, 8'd0, 2'b01);
                pos = 0;
            end else begin
                mlen = int'(b);
                pay_q.delete();
                pos = 2;
            end
        end else if (pos < mlen + 2) begin
            push_ev(c + 1, K_PL, b, 8'(pos - 2), 2'b00);
            pay_q.push_back(b);
            pos++;
        end else begin
            s = mlen;
            foreach (pay_q[i]) s += int'(pay_q[i]);
            if (b == 8'(s % 256)) push_ev(c + 1, K_OK, 8'd0, 8'd0, 2'b00);
            else                  push_ev(c + 1, K_ERR, 8'd0, 8'd0, 2'b10);
            pos = 0;
        end
        last_c = c;
    endfunction

    // ---------------- driver tasks (start and end on a negedge) ----------------
    task automatic send_byte(input logic [7:0] b);
        model_byte(b, cyc);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        model_tick_to(cyc + n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bytes(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) send_byte(v[(n - 1 - i) * 8 +: 8]);
    endtask

    task automatic rand_gap(input int gmax);
        int n;
        if ($urandom_range(0, 30) == 0) n = $urandom_range(TMO - 1, TMO);
        else                            n = $urandom_range(0, gmax);
        if (n > 0) idle(n);
    endtask

    task automatic send_frame(input int len, input bit good, input int gmax, input int cut);
        logic [7:0] s, b;
        s = 8'(len);
        send_byte(HDR);
        rand_gap(gmax);
        send_byte(8'(len));
        for (int i = 0; i < len && i < cut; i++) begin
            b = 8'($urandom);
            s = s + b;
            rand_gap(gmax);
            send_byte(b);
        end
        if (cut < len) begin
            idle(TMO + 3);
        end else begin
            rand_gap(gmax);
            send_byte(good ? s : s + 8'($urandom_range(1, 255)));
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        total++;
        if ({pl_data, pl_valid, pl_idx, frame_ok, frame_err, err_code, busy} !== 22'd0) begin
            bad++;
            $display("FAIL %s: got data=%h valid=%b idx=%h ok=%b err=%b code=%b busy=%b, want all 0",
                     name, pl_data, pl_valid, pl_idx, frame_ok, frame_err, err_code, busy);
        end
    endtask

    task automatic chk_not_busy(input string name);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: busy=%b, want 0", name, busy);
        end
    endtask

    // ---------------- monitor ----------------
    logic [7:0] last_d = 8'd0, last_i = 8'd0;
    logic [1:0] exp_code = 2'b00;

    task automatic check_ev(input string name, input logic [W-1:0] act);
        logic [W-1:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected strobe got=%h, want none", name, act);
        end else begin
            e = exp_q.pop_front();
            if (e[1:0] != 2'b00 || e[19:18] == K_ERR) exp_code = e[1:0];
            if (e !== act) begin
                bad++;
                $display("FAIL %s: got cyc=%0d k=%0d d=%h i=%h c=%b, want cyc=%0d k=%0d d=%h i=%h c=%b",
                         name, act[51:20], act[19:18], act[17:10], act[9:2], act[1:0],
                         e[51:20], e[19:18], e[17:10], e[9:2], e[1:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] cv;
        cv = cyc;
        if (rst) begin
            last_d   = 8'd0;
            last_i   = 8'd0;
            exp_code = 2'b00;
        end else begin
            if (frame_ok && frame_err) begin
                total++;
                bad++;
                $display("FAIL ok_err_both: ok=1 err=1, want at most one");
            end
            if (pl_valid) begin
                check_ev("payload", {cv, K_PL, pl_data, pl_idx, 2'b00});
                last_d = pl_data;
                last_i = pl_idx;
            end else begin
                total++;
                if (pl_data !== last_d || pl_idx !== last_i) begin
                    bad++;
                    $display("FAIL pl_hold: got %h/%h, want %h/%h", pl_data, pl_idx, last_d, last_i);
                end
            end
            if (frame_ok)  check_ev("frame_ok", {cv, K_OK, 8'd0, 8'd0, 2'b00});
            if (frame_err) check_ev("frame_err", {cv, K_ERR, 8'd0, 8'd0, err_code});
            if (frame_ok || frame_err) chk_not_busy("busy_drop");
            total++;
            if (err_code !== exp_code) begin
                bad++;
                $display("FAIL err_code_hold: got %b, want %b", err_code, exp_code);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int len, k;
        rst     = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);

        send_bytes(64'hA5_03_11_22_33_69, 6);      // good frame
        idle(3);
        send_bytes(64'hA5_03_11_22_33_6A, 6);      // bad checksum
        idle(3);
        send_bytes(64'hA5_00, 2);                  // zero length
        idle(2);
        send_bytes(64'hA5_11, 2);                  // length above maximum
        idle(2);
        send_bytes(64'hA5_10, 2);                  // length exactly at maximum
        for (int i = 0; i < MAXL; i++) send_byte(8'(i));
        send_byte(8'd16 + 8'd120);
        idle(2);
        send_byte(8'h00); chk_not_busy("junk_00");
        send_byte(8'hFF); chk_not_busy("junk_ff");
        send_byte(8'h5A); chk_not_busy("junk_5a");
        send_bytes(64'hA5_01_7E_7F, 4);
        idle(2);
        send_bytes(64'hA5_02_10, 3);               // stall mid-frame
        idle(TMO);
        send_bytes(64'hA5_01_05_06, 4);
        idle(2);
        send_bytes(64'hA5_01, 2);                  // byte lands exactly on the last quiet cycle
        idle(TMO - 1);
        send_bytes(64'h05_06, 2);
        idle(2);
        send_bytes(64'hA5_02, 2);                  // reset mid-frame
        idle(1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midframe_reset");
        rst = 1'b0;
        pos = 0;
        send_bytes(64'h10_20, 2);
        idle(3);

        for (int f = 0; f < 70; f++) begin
            k = $urandom_range(0, 9);
            if (k == 0) begin
                send_byte(8'($urandom));
            end else begin
                len = (k == 1) ? $urandom_range(0, MAXL + 3) : $urandom_range(1, MAXL);
                send_frame(len, $urandom_range(0, 4) != 0, (k == 2) ? 3 : 0,
                           ($urandom_range(0, 12) == 0) ? $urandom_range(0, len) : len);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end

        idle(TMO + 5);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected events never seen, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
